// File: rtl/pe_pkg.sv
// Shared PE datapath definitions for the dot-product accumulator and int2float32.
// Holds the operand/accumulator widths, the symmetric clamp limits and the
// accumulator FSM state encoding.
package pe_pkg;

  localparam int PE_DATA_W = 16;
  localparam int PE_ACC_W  = 32;
  localparam int PE_LEN_W  = 8;

  // Symmetric clamp range: -2^31 is never produced, because the int2float32
  // sign-fix (negate) path cannot represent its magnitude.
  localparam logic [PE_ACC_W-1:0] ACC_POS_MAX = 32'h7FFF_FFFF;
  localparam logic [PE_ACC_W-1:0] ACC_NEG_MAX = 32'h8000_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } pe_state_e;

endpackage

// File: rtl/sat_add32.sv
// Purpose:  33-bit signed add of accumulator and product, clamped to +/-(2^31-1).
// Latency:  combinational.
// Backpressure: none (pure function of its inputs).
// Ports: acc_dat/prod_dat signed addends in, sum_dat clamped sum out,
//        sat_dat high when the clamp was applied.
module sat_add32
  import pe_pkg::*;
(
  input  logic [PE_ACC_W-1:0] acc_dat,
  input  logic [PE_ACC_W-1:0] prod_dat,
  output logic [PE_ACC_W-1:0] sum_dat,
  output logic                sat_dat
);

  localparam logic signed [PE_ACC_W:0] POS_LIM = {1'b0, ACC_POS_MAX};
  localparam logic signed [PE_ACC_W:0] NEG_LIM = {1'b1, ACC_NEG_MAX};

  logic signed [PE_ACC_W:0] sum33;

  always_comb begin
    sum33   = $signed({acc_dat[PE_ACC_W-1], acc_dat}) +
              $signed({prod_dat[PE_ACC_W-1], prod_dat});
    sum_dat = sum33[PE_ACC_W-1:0];
    sat_dat = 1'b0;
    if (sum33 > POS_LIM) begin
      sum_dat = ACC_POS_MAX;
      sat_dat = 1'b1;
    end else if (sum33 < NEG_LIM) begin
      sum_dat = ACC_NEG_MAX;
      sat_dat = 1'b1;
    end
  end

endmodule

// File: rtl/pe_int_dot_accum32.sv
// Purpose:  streaming signed dot product of cfg_len operand pairs into a saturating 32-bit sum.
// Latency:  result valid on the edge after the flush cycle (2nd edge counting the last accept edge).
// Backpressure: in_ready low during FLUSH/OUT; result held stable in OUT until out_ready.
// Ports: clk/rst_n (async active-low), clr sync soft clear, cfg_len vector length
//        (0 = 2^LEN_W), in_valid/in_ready/in_a/in_b operand stream,
//        out_valid/out_ready/out_sum/out_sat result stream.
module pe_int_dot_accum32
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int LEN_W  = PE_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat
);

  pe_state_e             state_q, state_d;
  logic [LEN_W:0]        cnt_q, cnt_d;
  logic [LEN_W:0]        len_q, len_d;
  logic [2*DATA_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  sat_q, sat_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_W-1:0]      out_sum_q, out_sum_d;
  logic                  out_sat_q, out_sat_d;

  logic                  accept;
  logic [LEN_W:0]        len_dec;
  logic [LEN_W:0]        cnt_inc;
  logic [2*DATA_W-1:0]   a_ext;
  logic [2*DATA_W-1:0]   b_ext;
  logic [ACC_W-1:0]      add_sum;
  logic                  add_sat;

  sat_add32 u_sat_add (
    .acc_dat  (acc_q),
    .prod_dat (prod_q),
    .sum_dat  (add_sum),
    .sat_dat  (add_sat)
  );

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

  // Length field 0 stands for the full 2^LEN_W; the extra bit keeps it unambiguous.
  assign len_dec = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
  assign cnt_inc = cnt_q + 1'b1;

  // Sign-extend before multiplying so the low 2*DATA_W bits are the signed product.
  assign a_ext = {{DATA_W{in_a[DATA_W-1]}}, in_a};
  assign b_ext = {{DATA_W{in_b[DATA_W-1]}}, in_b};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    // prod_q returns to zero when no beat is accepted, so adding it during
    // input gaps leaves the accumulator unchanged.
    prod_d      = accept ? (a_ext * b_ext) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = len_dec;
          cnt_d   = {{LEN_W{1'b0}}, 1'b1};
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = (len_dec == {{LEN_W{1'b0}}, 1'b1}) ? ST_FLUSH : ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = add_sum;
        sat_d = sat_q | add_sat;
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Folds in the last product and loads the result registers directly.
        acc_d       = add_sum;
        sat_d       = sat_q | add_sat;
        out_sum_d   = add_sum;
        out_sat_d   = sat_q | add_sat;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      prod_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
